// File: rtl/spc_stack.sv
// rtl/spc_stack.sv - parametrised subroutine-PC return stack with registered top and sticky errors
module spc_stack #(
  parameter int WIDTH      = 19,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  state_fetch,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      top,
  output logic [DEPTH_LOG2-1:0] ptr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  unf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_top;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_do_push;
  logic                  w_do_pop;
  logic                  w_do_repl;
  logic [DEPTH_LOG2-1:0] w_ptr_inc;
  logic [DEPTH_LOG2-1:0] w_ptr_dec;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_en;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic                  w_set_ovf;
  logic                  w_set_unf;

  // Decode the committed operation; nothing moves unless the fetch strobe is high.
  assign w_do_push = state_fetch & push & ~pop;
  assign w_do_pop  = state_fetch & pop  & ~push;
  assign w_do_repl = state_fetch & push & pop;

  // Pointer arithmetic wraps naturally at DEPTH_LOG2 bits.
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_ptr_dec = r_ptr - 1'b1;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // Push lands one above the current top; replace overwrites the top slot in place.
  assign w_wr_en   = ~reset & (w_do_push | w_do_repl);
  assign w_wr_addr = w_do_push ? w_ptr_inc : r_ptr;

  assign w_set_ovf = w_do_push & w_full;
  assign w_set_unf = w_do_pop & w_empty;

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= wdata;
    end
  end

  // Pointer, occupancy and registered top-of-stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_top   <= '0;
    end else if (w_do_push) begin
      r_ptr <= w_ptr_inc;
      r_top <= wdata;
      if (!w_full) begin
        r_count <= r_count + C_ONE;
      end
    end else if (w_do_pop) begin
      // The read sees pre-edge contents; a pop never writes, so no hazard.
      r_ptr <= w_ptr_dec;
      r_top <= r_mem[w_ptr_dec];
      if (!w_empty) begin
        r_count <= r_count - C_ONE;
      end
    end else if (w_do_repl) begin
      // Forward wdata rather than reading back the slot being written.
      r_top <= wdata;
      if (w_empty) begin
        r_count <= C_ONE;
      end
    end
  end

  // Sticky error flags: a set event beats a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
      r_unf <= w_set_unf | (r_unf & ~clr_err);
    end
  end

  assign top   = r_top;
  assign ptr   = r_ptr;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
